// File: rtl/bec_la_host.sv
// bec_la_host -- host-side initiator for the BEC accelerator LA command port.
//
// Takes an operand pair on a valid/ready command interface and writes it to
// the accelerator over the LA probe lines using the write/busy protocol.
// Waits for the accelerator to report done, lets the readback lines settle,
// and then captures the result and returns it on a valid/ready response
// interface.
//
// Optional feature: define BEC_HOST_TIMEOUT_EN to add a watchdog on the WAKE
// and RUN waits. When it expires, the host returns rsp_err=1 with rsp_sum=0.
// If the macro is not defined, those waits are unbounded and rsp_err is
// always 0.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_a, cmd_b          operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_sum, rsp_err      captured result / watchdog error flag
//   la_probe              {busy, sel, data} to accelerator la_data_in
//   la_oenb_n             active-low probe write enable
//   status_in             accelerator FSM pins (000 idle,100 write,010 busy,001 done)
//   sum_in                accelerator result readback
module bec_la_host #(
  parameter int DATA_W         = 3,
  parameter int SETUP_CYCLES   = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_err,
  output logic [DATA_W+1:0] la_probe,
  output logic              la_oenb_n,
  input  logic [2:0]        status_in,
  input  logic [DATA_W-1:0] sum_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam logic [2:0] ST_WRITE = 3'b100;
  localparam logic [2:0] ST_DONE  = 3'b001;

  // A single phase counter serves both the operand setup and the settle wait.
  localparam int PH_MAX = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PH_ONE       = PH_W'(1);
  localparam logic [PH_W-1:0] SETUP_LAST   = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST  = PH_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [PH_W-1:0]    r_phase;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W+1:0]  r_probe;
  logic               r_oenb_n;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_sum;
  logic               r_rsp_err;
  logic               w_wd_expired;

`ifdef BEC_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;

  // Only WAKE and RUN can follow a state where the count is held at zero, so
  // clearing outside those states is the same as clearing on every state entry.
  always_ff @(posedge clk) begin
    if (rst || !(r_state == S_WAKE || r_state == S_RUN)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WD_ONE;
    end
  end

  assign w_wd_expired = (r_wdog == WD_LAST);
`else
  assign w_wd_expired = 1'b0;
`endif

  // Combinational so that a command is never accepted during the reset cycle.
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_err   = r_rsp_err;
  assign la_probe  = r_probe;
  assign la_oenb_n = r_oenb_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_probe     <= '0;
      r_oenb_n    <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a      <= cmd_a;
            r_b      <= cmd_b;
            // Present operand A during WAKE so it is already stable when the
            // accelerator enters its write state.
            r_probe  <= {2'b00, cmd_a};
            r_oenb_n <= 1'b0;
            r_state  <= S_WAKE;
          end
        end

        S_WAKE: begin
          if (status_in == ST_WRITE) begin
            r_phase <= '0;
            r_state <= S_LOAD_A;
          end else if (w_wd_expired) begin
            r_oenb_n    <= 1'b1;
            r_probe     <= '0;
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_LOAD_A: begin
          if (r_phase == SETUP_LAST) begin
            r_probe <= {2'b01, r_b};
            r_phase <= '0;
            r_state <= S_LOAD_B;
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_LOAD_B: begin
          if (r_phase == SETUP_LAST) begin
            r_probe <= {2'b11, r_b};
            r_phase <= '0;
            r_state <= S_RUN;
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_RUN: begin
          if (status_in == ST_DONE) begin
            r_oenb_n <= 1'b1;
            r_probe  <= '0;
            r_phase  <= '0;
            r_state  <= S_DRAIN;
          end else if (w_wd_expired) begin
            r_oenb_n    <= 1'b1;
            r_probe     <= '0;
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_DRAIN: begin
          // The readback lines get SETTLE_CYCLES to settle after release.
          if (r_phase == SETTLE_LAST) begin
            r_rsp_sum   <= sum_in;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bec_la_host.sv
// Testbench for bec_la_host. It contains a behavioural accelerator that uses
// a 1026-cycle run. A scoreboard queue holds the expected {err, sum} for each
// accepted command. Entries are popped when the response handshake occurs.
module tb_bec_la_host;

  localparam int DATA_W   = 3;
  localparam int SETUP    = 2;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 2048;
  localparam int RUN_CYC  = 1026;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_sum;
  logic              rsp_err;
  logic [DATA_W+1:0] la_probe;
  logic              la_oenb_n;
  logic [2:0]        status_in;
  logic [DATA_W-1:0] sum_in;

  int n_checks = 0;
  int n_fail   = 0;
  int last_k   = 0;
  logic [DATA_W:0] sb[$];

  bec_la_host #(
    .DATA_W(DATA_W), .SETUP_CYCLES(SETUP), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .la_probe(la_probe), .la_oenb_n(la_oenb_n), .status_in(status_in), .sum_in(sum_in)
  );

  always #5 clk = ~clk;

  // Behavioural accelerator: it reports "write" while the port is enabled and
  // busy is low. The operands are taken by sel. After busy rises, it counts
  // RUN_CYC cycles and then reports "done" with the wrapped sum.
  logic [2:0]        acc_status;
  logic [DATA_W-1:0] acc_n1, acc_n2, acc_sum;
  int                acc_cnt;
  bit                acc_stuck = 1'b0;

  always @(posedge clk) begin
    if (rst || la_oenb_n) begin
      acc_status <= 3'b000;
      acc_cnt    <= 0;
    end else if (!la_probe[DATA_W+1]) begin
      acc_status <= 3'b100;
      if (la_probe[DATA_W]) acc_n2 <= la_probe[DATA_W-1:0];
      else                  acc_n1 <= la_probe[DATA_W-1:0];
    end else if (acc_cnt < RUN_CYC) begin
      acc_status <= 3'b010;
      acc_cnt    <= acc_cnt + 1;
    end else begin
      acc_status <= 3'b001;
      acc_sum    <= acc_n1 + acc_n2;
    end
  end

  assign status_in = acc_stuck ? 3'b000 : acc_status;
  assign sum_in    = acc_sum;

  // Probe monitor: it counts the operand-A cycles after the write status is
  // seen, and the operand-B cycles before busy rises.
  bit                mon_en = 1'b0;
  bit                mon_seen;
  int                mon_cnt_a, mon_cnt_b, mon_bad;
  logic [DATA_W-1:0] mon_a, mon_b;

  always @(negedge clk) begin
    if (mon_en && !la_oenb_n && !la_probe[DATA_W+1]) begin
      if (!la_probe[DATA_W] && mon_seen) begin
        mon_cnt_a++;
        if (la_probe[DATA_W-1:0] !== mon_a) mon_bad++;
      end
      if (la_probe[DATA_W]) begin
        mon_cnt_b++;
        if (la_probe[DATA_W-1:0] !== mon_b) mon_bad++;
      end
      if (status_in == 3'b100) mon_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge after the handshake edge.
  task automatic do_cmd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit expect_rsp,
                        input logic exp_err);
    int k = 0;
    logic [DATA_W-1:0] s;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    s = a + b;
    if (expect_rsp) sb.push_back(exp_err ? {1'b1, {DATA_W{1'b0}}} : {1'b0, s});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wake_oenb_low", {31'd0, la_oenb_n}, 32'd0);
  endtask

  task automatic wait_rsp(input int budget, input bit timing, input int hold);
    int k = 0;
    int done_at = -1;
    logic [DATA_W:0] exp;
    logic [DATA_W-1:0] held;
    while (!rsp_valid && k < budget) begin
      @(negedge clk);
      k++;
      if (status_in == 3'b001 && done_at < 0) done_at = k;
      if (done_at >= 0 && k == done_at + 1) begin
        check("release_oenb", {31'd0, la_oenb_n}, 32'd1);
        check("release_probe", {27'd0, la_probe}, 32'd0);
      end
    end
    last_k = k;
    check("rsp_valid_in_budget", {31'd0, rsp_valid}, 32'd1);
    if (!rsp_valid) return;
    if (timing) check("rsp_latency", k - done_at, SETTLE + 1);
    held = rsp_sum;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_sum", {29'd0, rsp_sum}, {29'd0, held});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (i == 5) begin
        cmd_a = 3'd1; cmd_b = 3'd1; cmd_valid = 1'b1;
      end
      if (i == 7) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_has_entry", sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      check("rsp_sum", {29'd0, rsp_sum}, {29'd0, exp[DATA_W-1:0]});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp[DATA_W]});
      $display("rsp: sum=%0d err=%0d (expected sum=%0d err=%0d)", rsp_sum, rsp_err,
               exp[DATA_W-1:0], exp[DATA_W]);
    end
    check("rsp_oenb_high", {31'd0, la_oenb_n}, 32'd1);
    check("rsp_probe_zero", {27'd0, la_probe}, 32'd0);
    @(negedge clk);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_sum", {29'd0, rsp_sum}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_probe", {27'd0, la_probe}, 32'd0);
    check("rst_oenb", {31'd0, la_oenb_n}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 3 + 2 = 5
    do_cmd(3'd3, 3'd2, 1'b1, 1'b0);
    wait_rsp(1500, 1'b1, 0);

    // 7 + 1 wraps to 0; check the probe operand phases
    mon_seen = 1'b0; mon_cnt_a = 0; mon_cnt_b = 0; mon_bad = 0;
    mon_a = 3'd7; mon_b = 3'd1; mon_en = 1'b1;
    do_cmd(3'd7, 3'd1, 1'b1, 1'b0);
    wait_rsp(1500, 1'b1, 0);
    mon_en = 1'b0;
    check("probe_a_cycles", mon_cnt_a, SETUP);
    check("probe_b_cycles", mon_cnt_b, SETUP);
    check("probe_data_bad", mon_bad, 0);

    // 4 + 2 = 6 with backpressure; a stray command must be ignored
    rsp_ready = 1'b0;
    do_cmd(3'd4, 3'd2, 1'b1, 1'b0);
    wait_rsp(1500, 1'b1, 20);
    repeat (5) @(negedge clk);
    check("no_stray_start", {31'd0, la_oenb_n}, 32'd1);
    check("no_stray_rsp", {31'd0, rsp_valid}, 32'd0);

    // Accelerator never reports write
    acc_stuck = 1'b1;
`ifdef BEC_HOST_TIMEOUT_EN
    do_cmd(3'd2, 3'd3, 1'b1, 1'b1);
    wait_rsp(3000, 1'b0, 0);
    check("timeout_cycles", last_k, TIMEOUT);
    acc_stuck = 1'b0;
`else
    do_cmd(3'd2, 3'd3, 1'b0, 1'b0);
    k = 0;
    repeat (2200) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    check("no_watchdog_rsp", k, 0);
    check("no_watchdog_oenb", {31'd0, la_oenb_n}, 32'd0);
    check("no_watchdog_err", {31'd0, rsp_err}, 32'd0);
    acc_stuck = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset during RUN drops the transaction
    do_cmd(3'd5, 3'd6, 1'b1, 1'b0);
    k = 0;
    while (!la_probe[DATA_W+1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("busy_seen", {31'd0, la_probe[DATA_W+1]}, 32'd1);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_probe", {27'd0, la_probe}, 32'd0);
    check("rst_run_oenb", {31'd0, la_oenb_n}, 32'd1);
    check("rst_run_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    check("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    do_cmd(3'd1, 3'd1, 1'b1, 1'b0);
    wait_rsp(1500, 1'b1, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
